// File: rtl/writeback_unit.sv
// Final pipeline stage: retires ALU/CSR results, waits for and aligns load data,
// drives the register file write port and keeps the retired-instruction counter.
module writeback_unit #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_byte_off,
  input  logic [31:0] in_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        stall,
  output logic        rf_write_en,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd_data,
  output logic        load_fault,
  output logic [63:0] instret,
  output logic        dbg_state
);

  // Handshake: in_valid is sampled only while stall is low; dmem_rvalid is
  // honoured only while a load is outstanding and is a single-cycle pulse.
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam int unsigned CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((LOAD_TIMEOUT == 0) ? 0 : LOAD_TIMEOUT - 1);

  state_t        state_q, state_n;
  logic [CW-1:0] to_cnt, to_cnt_n;
  logic [4:0]    lat_rd;
  logic          lat_we;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_off;

  logic          wr_en_n;
  logic [4:0]    wr_addr_n;
  logic [31:0]   wr_data_n;
  logic          fault_n;
  logic          retire_n;
  logic          capture_n;
  logic          timeout_hit;

  // Illegal width encodings and misaligned halfword/word accesses fault.
  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: load_bad = 1'b0;
      3'b001, 3'b101: load_bad = off[0];
      3'b010:         load_bad = (off != 2'b00);
      default:        load_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*off +: 8];
    h = rdata[16*off[1] +: 16];
    case (f3)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b100:  align_load = {24'd0, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b101:  align_load = {16'd0, h};
      default: align_load = rdata;
    endcase
  endfunction

  assign timeout_hit = (LOAD_TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_comb begin
    state_n   = state_q;
    to_cnt_n  = to_cnt;
    wr_en_n   = 1'b0;
    wr_addr_n = 5'd0;
    wr_data_n = 32'd0;
    fault_n   = 1'b0;
    retire_n  = 1'b0;
    capture_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            capture_n = 1'b1;
            to_cnt_n  = '0;
            state_n   = WAIT_LOAD;
          end else begin
            retire_n = 1'b1;
            if (in_reg_write && in_rd_addr != 5'd0) begin
              wr_en_n   = 1'b1;
              wr_addr_n = in_rd_addr;
              wr_data_n = in_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_n = IDLE;
          if (dmem_err || load_bad(lat_f3, lat_off)) begin
            fault_n = 1'b1;
          end else begin
            retire_n = 1'b1;
            if (lat_we && lat_rd != 5'd0) begin
              wr_en_n   = 1'b1;
              wr_addr_n = lat_rd;
              wr_data_n = align_load(lat_f3, lat_off, dmem_rdata);
            end
          end
        end else if (timeout_hit) begin
          state_n = IDLE;
          fault_n = 1'b1;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      to_cnt      <= '0;
      lat_rd      <= 5'd0;
      lat_we      <= 1'b0;
      lat_f3      <= 3'd0;
      lat_off     <= 2'd0;
      rf_write_en <= 1'b0;
      rf_rd_addr  <= 5'd0;
      rf_rd_data  <= 32'd0;
      load_fault  <= 1'b0;
      instret     <= 64'd0;
    end else begin
      state_q     <= state_n;
      to_cnt      <= to_cnt_n;
      rf_write_en <= wr_en_n;
      rf_rd_addr  <= wr_addr_n;
      rf_rd_data  <= wr_data_n;
      load_fault  <= fault_n;
      if (retire_n) instret <= instret + 64'd1;
      if (capture_n) begin
        lat_rd  <= in_rd_addr;
        lat_we  <= in_reg_write;
        lat_f3  <= in_funct3;
        lat_off <= in_byte_off;
      end
    end
  end

  assign stall     = (state_q == WAIT_LOAD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU retire, load alignment, load faults,
// timeout, back-to-back issue, reset during a load and instret wrap.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_reg_write;
  logic [4:0]  in_rd_addr;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_byte_off;
  logic [31:0] in_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        stall;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        load_fault;
  logic [63:0] instret;
  logic        dbg_state;

  int          checks;
  int          errors;
  logic [63:0] exp_instret;

  writeback_unit #(.LOAD_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
    .in_result(in_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .stall(stall), .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .load_fault(load_fault), .instret(instret),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_reg_write = 1'b0;
    in_rd_addr   = 5'd0;
    in_is_load   = 1'b0;
    in_funct3    = 3'd0;
    in_byte_off  = 2'd0;
    in_result    = 32'd0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = 32'd0;
    dmem_err     = 1'b0;
  endtask

  // Issues a load, waits gap cycles, then returns one response; counts stall cycles.
  task automatic run_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic err, input int gap,
                          output int n_stall);
    in_valid     = 1'b1;
    in_is_load   = 1'b1;
    in_reg_write = 1'b1;
    in_rd_addr   = rd;
    in_funct3    = f3;
    in_byte_off  = off;
    tick();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    n_stall    = 0;
    for (int i = 0; i < gap; i++) begin
      if (stall) n_stall++;
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    dmem_err    = err;
    if (stall) n_stall++;
    tick();
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({stall, rf_write_en, rf_rd_addr, rf_rd_data, load_fault, dbg_state} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b we=%b addr=%0d data=%h fault=%b st=%b want all 0",
               stall, rf_write_en, rf_rd_addr, rf_rd_data, load_fault, dbg_state);
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_instret got %0d want 0", instret);
    end
    exp_instret = 64'd0;
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd5; in_result = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    exp_instret++;
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL alu_rd5 got we=%b addr=%0d data=%h want 1/5/deadbeef",
               rf_write_en, rf_rd_addr, rf_rd_data);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL alu_rd5_instret got %0d want %0d", instret, exp_instret);
    end
    in_valid = 1'b1; in_rd_addr = 5'd0; in_result = 32'h12345678;
    tick();
    in_valid = 1'b0;
    exp_instret++;
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data} !== 38'd0) begin
      errors++;
      $display("FAIL alu_rd0 got we=%b addr=%0d data=%h want 0/0/0",
               rf_write_en, rf_rd_addr, rf_rd_data);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL alu_rd0_instret got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_load_align();
    logic [2:0]  f3_v[4]   = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  off_v[4]  = '{2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] want_v[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    int n;
    for (int k = 0; k < 4; k++) begin
      run_load(f3_v[k], off_v[k], 5'd7, 32'h80FF1234, 1'b0, 4, n);
      exp_instret++;
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL load%0d_stall_cycles got %0d want 5", k, n);
      end
      checks++;
      if ({rf_write_en, rf_rd_addr, rf_rd_data, stall, load_fault} !== {1'b1, 5'd7, want_v[k], 2'b00}) begin
        errors++;
        $display("FAIL load%0d_data got we=%b addr=%0d data=%h stall=%b fault=%b want 1/7/%h/0/0",
                 k, rf_write_en, rf_rd_addr, rf_rd_data, stall, load_fault, want_v[k]);
      end
      checks++;
      if (instret !== exp_instret) begin
        errors++;
        $display("FAIL load%0d_instret got %0d want %0d", k, instret, exp_instret);
      end
    end
  endtask

  task automatic test_load_fault();
    logic [2:0] f3_v[4]  = '{3'b010, 3'b011, 3'b000, 3'b001};
    logic [1:0] off_v[4] = '{2'd2, 2'd0, 2'd0, 2'd1};
    logic       err_v[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int n;
    for (int k = 0; k < 4; k++) begin
      run_load(f3_v[k], off_v[k], 5'd8, 32'h11223344, err_v[k], 1, n);
      checks++;
      if ({load_fault, rf_write_en, rf_rd_addr, rf_rd_data} !== {1'b1, 38'd0}) begin
        errors++;
        $display("FAIL fault%0d got fault=%b we=%b addr=%0d data=%h want 1/0/0/0",
                 k, load_fault, rf_write_en, rf_rd_addr, rf_rd_data);
      end
      checks++;
      if (instret !== exp_instret) begin
        errors++;
        $display("FAIL fault%0d_instret got %0d want %0d", k, instret, exp_instret);
      end
      tick();
      checks++;
      if (load_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault%0d_pulse got %b want 0", k, load_fault);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    in_valid = 1'b1; in_is_load = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd6;
    in_funct3 = 3'b010; in_byte_off = 2'd0;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    n = 0;
    while (stall && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL timeout_stall_cycles got %0d want 8", n);
    end
    checks++;
    if ({load_fault, stall, rf_write_en} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_fault got fault=%b stall=%b we=%b want 1/0/0", load_fault, stall, rf_write_en);
    end
    tick();
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA5555;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data, stall, load_fault} !== 39'd0) begin
      errors++;
      $display("FAIL late_rvalid got we=%b addr=%0d data=%h stall=%b fault=%b want all 0",
               rf_write_en, rf_rd_addr, rf_rd_data, stall, load_fault);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL late_rvalid_instret got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_is_load = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd4;
    in_funct3 = 3'b010; in_byte_off = 2'd0;
    tick();
    // A non-load held on the input while stalled must wait for the load.
    in_is_load = 1'b0; in_rd_addr = 5'd9; in_result = 32'h00000999;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall got %b want 1", stall);
    end
    tick();
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    exp_instret++;
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data, stall} !== {1'b1, 5'd4, 32'hCAFEF00D, 1'b0}) begin
      errors++;
      $display("FAIL b2b_load got we=%b addr=%0d data=%h stall=%b want 1/4/cafef00d/0",
               rf_write_en, rf_rd_addr, rf_rd_data, stall);
    end
    tick();
    exp_instret++;
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data} !== {1'b1, 5'd9, 32'h00000999}) begin
      errors++;
      $display("FAIL b2b_alu got we=%b addr=%0d data=%h want 1/9/00000999",
               rf_write_en, rf_rd_addr, rf_rd_data);
    end
    in_result = 32'h00000111; in_rd_addr = 5'd10;
    tick();
    in_valid = 1'b0;
    exp_instret++;
    tick();
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data} !== 38'd0) begin
      errors++;
      $display("FAIL b2b_idle got we=%b addr=%0d data=%h want 0/0/0", rf_write_en, rf_rd_addr, rf_rd_data);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL b2b_instret got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1; in_is_load = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd11;
    in_funct3 = 3'b000; in_byte_off = 2'd0;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_instret = 64'd0;
    checks++;
    if ({stall, rf_write_en, load_fault} !== 3'b000 || instret !== 64'd0) begin
      errors++;
      $display("FAIL midload_reset got stall=%b we=%b fault=%b instret=%0d want 0/0/0/0",
               stall, rf_write_en, load_fault, instret);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h000000FF;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({stall, rf_write_en, rf_rd_addr, rf_rd_data} !== 39'd0 || instret !== 64'd0) begin
      errors++;
      $display("FAIL midload_rvalid got stall=%b we=%b addr=%0d data=%h instret=%0d want all 0",
               stall, rf_write_en, rf_rd_addr, rf_rd_data, instret);
    end
  endtask

  task automatic test_instret_wrap();
    force dut.instret = 64'hFFFFFFFFFFFFFFFF;
    #1;
    release dut.instret;
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd3; in_result = 32'h0000ABCD;
    tick();
    in_valid = 1'b0;
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL instret_wrap got %h want 0", instret);
    end
    checks++;
    if ({rf_write_en, rf_rd_addr, rf_rd_data} !== {1'b1, 5'd3, 32'h0000ABCD}) begin
      errors++;
      $display("FAIL wrap_write got we=%b addr=%0d data=%h want 1/3/0000abcd",
               rf_write_en, rf_rd_addr, rf_rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_instret = 64'd0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_load_align();
    test_load_fault();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    test_instret_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
